tree_psum_acc: RTL and testbench
================================

# tree_psum_acc

Downstream consumer of the 16-input adder tree. Takes the tree's final-level result stream, aligns it with the tree pipeline delay, and accumulates a programmable number of consecutive results into one partial-sum word. Completed words go through a small output FIFO to the writeback path over a valid/ready handshake. Input backpressure to the PE feeder guarantees no result is ever dropped.

## Interface
- ACC_BW, 32: width of tree result and accumulated word
- TREE_LAT, 2: cycles from tree inputs to tree final-level result
- CNT_BW, 8: width of group-length field
- DEPTH, 4: output FIFO entries; must be ≥ TREE_LAT+1
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- in_valid  in  1  tree inputs valid this cycle; counts only when in_ready=1
- in_ready  out  1  feeder may present a beat
- tree_sum  in  ACC_BW  tree final-level result; valid TREE_LAT cycles after the matching beat
- acc_len  in  CNT_BW  tree results per output word; 0 is treated as 1
- flush  in  1  close the current partial group
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  ACC_BW  accumulated word
- out_partial  out  1  word was closed by flush, not by count
- busy  out  1  pipeline, accumulator or FIFO non-empty

## Operation
- Accepted beat: in_valid & in_ready. A TREE_LAT-deep valid shift register produces the aligned strobe v_al, which samples tree_sum.
- FSM states:
  - IDLE: cnt=0, acc=0.
  - ACC: group open.
  - FLUSH_WAIT: flush pending, FIFO full.
- Transitions:
  - IDLE→ACC on v_al, unless the group completes on that beat.
  - ACC→IDLE when a word is pushed.
  - Any state→FLUSH_WAIT when flush is requested and the FIFO is full.
  - FLUSH_WAIT→IDLE when the push happens.
- acc_len is sampled into len_q on the first v_al of a group. Changes mid-group are ignored.
- On each v_al: acc_next = acc + tree_sum, cnt_next = cnt+1.
  - If cnt_next == len_q, push {acc_next, partial=0}, then clear acc and cnt.
- Flush:
  - Registered as pending.
  - Executes when the FIFO is not full. If cnt>0 (or a v_al arrives the same cycle), push {acc_next, partial=1} and clear. If the group is empty, clear pending with no push.
  - flush and a completing v_al in the same cycle produce one push with partial=0.
- in_ready = (DEPTH − fifo_cnt) > TREE_LAT. This is conservative and prevents FIFO overflow from in-flight beats.
- FIFO:
  - Read on out_valid & out_ready.
  - Simultaneous read and write when full is allowed.
  - Write when full never occurs by construction. The bench asserts this.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_data=0, out_partial=0, busy=0.
  - acc, cnt, len_q, valid pipe, FIFO pointers and flush-pending all cleared.
- Reset asserted mid-group discards in-flight beats and FIFO contents. Outputs take reset values the cycle after the rst edge.
- A beat accepted at cycle t gives v_al at t+TREE_LAT. A push on that edge gives out_valid at t+TREE_LAT+1 (3 cycles with defaults).
- A flush sampled at cycle t with the FIFO not full gives out_valid at t+1 (t+2 if registered behind a pending v_al).
- in_ready is a registered function of fifo_cnt. It updates the cycle after a push or pop.
- out_data/out_partial are held stable while out_valid=1 and out_ready=0.

## Configuration
- TREE_PSUM_ACC_SAT_EN defined: the accumulate add saturates to 2^ACC_BW−1 on carry-out.
- Undefined: the add wraps modulo 2^ACC_BW.

## Structure
- Package tree_psum_acc_pkg holds:
  - State enum {IDLE, ACC, FLUSH_WAIT}.
  - FIFO entry struct {data, partial}.
  - Saturating-add function, guarded by the macro.
- One sub-module, tree_psum_fifo: parameterized synchronous FIFO (DEPTH, entry type) with full/empty/count.

## Test plan
- acc_len=4, tree_sum 1,2,3,4 on consecutive aligned cycles → one word 10, partial=0, out_valid 3 cycles after the last accepted beat.
- acc_len=0, three beats with sums 7,8,9 → three words 7,8,9, each partial=0.
- acc_len=8, sums 5,5,5, then flush → one word 15, partial=1. The next group starts from 0.
- Saturation: acc_len=2, sums 0xFFFF_FFF0 and 0x20 → 0xFFFF_FFFF with the macro, 0x0000_0010 without.
- Backpressure: acc_len=1, out_ready=0, continuous in_valid → in_ready drops once fifo_cnt=2. FIFO reaches 4 with no loss. Releasing out_ready drains in order.
- Reset asserted two cycles into a 4-beat group → out_valid stays 0. A following fresh group of 1,1,1,1 yields 4.

Source files
------------

// File: rtl/tree_psum_acc_pkg.sv
// Shared types and helpers for the adder-tree partial-sum accumulator.
// TREE_PSUM_ACC_SAT_EN enables the saturating accumulate helper.
package tree_psum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        FLUSH_WAIT
    } state_t;

    localparam int unsigned PSUM_BW_DFLT = 32;

    typedef struct packed {
        logic [PSUM_BW_DFLT-1:0] data;
        logic                    partial;
    } psum_entry_t;

`ifdef TREE_PSUM_ACC_SAT_EN
    // Operands are zero-extended into 64 bits, so this covers any bw up to 63.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned bw);
        logic [63:0] lim;
        logic [63:0] s;
        lim = (64'd1 << bw) - 64'd1;
        s   = a + b;
        return (s > lim) ? lim : s;
    endfunction
`endif

endpackage

// File: rtl/tree_psum_acc_fifo.sv
// Small synchronous FIFO with full/empty/occupancy, generic over the entry type.
module tree_psum_fifo
    import tree_psum_acc_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type T = psum_entry_t,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  T              wr_data,
    input  logic          rd_en,
    output T              rd_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= next_ptr(wr_ptr);
            if (rd_en) rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/tree_psum_acc.sv
// Aligns adder-tree results, accumulates acc_len of them per word, queues words out.
// Define TREE_PSUM_ACC_SAT_EN for a saturating accumulate (ACC_BW <= 63); default wraps.
module tree_psum_acc
    import tree_psum_acc_pkg::*;
#(
    parameter int unsigned ACC_BW   = 32,
    parameter int unsigned TREE_LAT = 2,
    parameter int unsigned CNT_BW   = 8,
    parameter int unsigned DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ACC_BW-1:0] tree_sum,
    input  logic [CNT_BW-1:0] acc_len,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_BW-1:0] out_data,
    output logic              out_partial,
    output logic              busy
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ACC_BW-1:0] data;
        logic              partial;
    } entry_t;

    state_t            state;
    logic [ACC_BW-1:0] acc;
    logic [ACC_BW-1:0] acc_sum;
    logic [ACC_BW-1:0] acc_next;
    logic [CNT_BW-1:0] cnt;
    logic [CNT_BW-1:0] cnt_next;
    logic [CNT_BW-1:0] len_q;
    logic [CNT_BW-1:0] len_eff;
    logic [CNT_BW-1:0] len_use;
    logic [TREE_LAT-1:0] vpipe;
    logic              accept;
    logic              v_al;
    logic              complete;
    logic              flush_req;
    logic              flush_exec;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_cnt;
    logic [CW-1:0]     fifo_cnt_next;
    entry_t            wr_entry;
    entry_t            head;

    assign accept = in_valid & in_ready;
    assign v_al   = vpipe[TREE_LAT-1];
    assign pop    = out_valid & out_ready;

`ifdef TREE_PSUM_ACC_SAT_EN
    assign acc_sum = ACC_BW'(sat_add(64'(acc), 64'(tree_sum), ACC_BW));
`else
    assign acc_sum = acc + tree_sum;
`endif

    always_comb begin
        len_eff    = (acc_len == '0) ? CNT_BW'(1) : acc_len;
        // The first beat of a group compares against the live length, later ones against len_q.
        len_use    = (cnt == '0) ? len_eff : len_q;
        acc_next   = v_al ? acc_sum : acc;
        cnt_next   = cnt + CNT_BW'(v_al);
        complete   = v_al && (cnt_next == len_use);
        flush_req  = flush || (state == FLUSH_WAIT);
        flush_exec = flush_req && !fifo_full;
        push       = complete || (flush_exec && (v_al || (cnt != '0)));
        wr_entry.data    = acc_next;
        wr_entry.partial = !complete;
        fifo_cnt_next    = fifo_cnt + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            len_q    <= '0;
            vpipe    <= '0;
            in_ready <= 1'b1;
        end else begin
            vpipe <= TREE_LAT'({vpipe, accept});
            if (v_al && (cnt == '0)) len_q <= len_eff;

            if (push || flush_exec) begin
                acc <= '0;
                cnt <= '0;
            end else if (v_al) begin
                acc <= acc_sum;
                cnt <= cnt_next;
            end

            // FLUSH_WAIT doubles as the pending-flush flag.
            if (flush_req && fifo_full)  state <= FLUSH_WAIT;
            else if (push || flush_exec) state <= IDLE;
            else if (v_al)               state <= ACC;

            in_ready <= (DEPTH - 32'(fifo_cnt_next)) > TREE_LAT;
        end
    end

    tree_psum_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );

    assign out_valid   = !fifo_empty;
    assign out_data    = out_valid ? head.data : '0;
    assign out_partial = out_valid & head.partial;
    assign busy        = (|vpipe) || (cnt != '0) || !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_tree_psum_acc.sv
// Directed bench for tree_psum_acc: models the adder tree delay and scoreboards output words.
module tb_tree_psum_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] tree_sum;
    logic [7:0]  acc_len;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_partial;
    logic        busy;

    logic [31:0] feed_sum;
    logic [31:0] sp0;
    logic [31:0] sp1;
    logic [31:0] got_data [$];
    logic        got_part [$];
    int          checks   = 0;
    int          failures = 0;
    int          acc_n;
    int          drop;

    always #5 clk = ~clk;

    tree_psum_acc #(
        .ACC_BW   (32),
        .TREE_LAT (2),
        .CNT_BW   (8),
        .DEPTH    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .tree_sum    (tree_sum),
        .acc_len     (acc_len),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_partial (out_partial),
        .busy        (busy)
    );

    // Two-stage tree model: the sum presented with a beat reappears two cycles later.
    always @(posedge clk) begin
        sp0 <= feed_sum;
        sp1 <= sp0;
    end
    assign tree_sum = sp1;

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_part.push_back(out_partial);
        end
    end

    always @(negedge clk) begin
        if (!rst && dut.push) check_eq("no_ovf", 64'(dut.fifo_full & ~dut.pop), 64'd0);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] s);
        int n;
        n = 0;
        in_valid = 1'b1;
        feed_sum = s;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check_eq("beat_timeout", 64'(in_ready), 64'd1);
        tick();
    endtask

    task automatic expect_word(input string tag, input logic [31:0] d, input logic p);
        int n;
        n = 0;
        while (got_data.size() == 0 && n < 40) begin
            tick();
            n++;
        end
        if (got_data.size() == 0) begin
            check_eq({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            check_eq({tag, "_data"}, 64'(got_data.pop_front()), 64'(d));
            check_eq({tag, "_part"}, 64'(got_part.pop_front()), 64'(p));
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        acc_len = '0; feed_sum = '0;
        tick();
        check_eq("rst_in_ready",    64'(in_ready),    64'd1);
        check_eq("rst_out_valid",   64'(out_valid),   64'd0);
        check_eq("rst_out_data",    64'(out_data),    64'd0);
        check_eq("rst_out_partial", 64'(out_partial), 64'd0);
        check_eq("rst_busy",        64'(busy),        64'd0);
        tick();
        rst = 1'b0;

        // Group of four, with output latency relative to the last beat
        acc_len = 8'd4;
        send_beat(1); send_beat(2); send_beat(3); send_beat(4);
        in_valid = 1'b0;
        check_eq("t1_lat1", 64'(out_valid), 64'd0);
        tick();
        check_eq("t1_lat2", 64'(out_valid), 64'd0);
        tick();
        check_eq("t1_lat3", 64'(out_valid), 64'd1);
        expect_word("t1", 32'd10, 1'b0);
        tick(); tick();
        check_eq("t1_idle_busy", 64'(busy), 64'd0);

        // acc_len = 0 behaves as 1
        acc_len = 8'd0;
        send_beat(7); send_beat(8); send_beat(9);
        in_valid = 1'b0;
        expect_word("t2a", 32'd7, 1'b0);
        expect_word("t2b", 32'd8, 1'b0);
        expect_word("t2c", 32'd9, 1'b0);

        // Flush closes a short group; next group starts from zero and ignores mid-group length change
        acc_len = 8'd8;
        send_beat(5); send_beat(5); send_beat(5);
        idle(2);
        flush = 1'b1;
        check_eq("t3_pre_flush", 64'(out_valid), 64'd0);
        tick();
        flush = 1'b0;
        check_eq("t3_flush_lat", 64'(out_valid), 64'd1);
        expect_word("t3", 32'd15, 1'b1);
        acc_len = 8'd2;
        send_beat(3); send_beat(4);
        in_valid = 1'b0;
        tick();
        acc_len = 8'd8;
        expect_word("t3_len", 32'd7, 1'b0);

        // Accumulate overflow
        acc_len = 8'd2;
        send_beat(32'hFFFF_FFF0); send_beat(32'h0000_0020);
        in_valid = 1'b0;
`ifdef TREE_PSUM_ACC_SAT_EN
        expect_word("t4_sat", 32'hFFFF_FFFF, 1'b0);
`else
        expect_word("t4_wrap", 32'h0000_0010, 1'b0);
`endif

        // Flush of an empty group pushes nothing
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle(5);
        check_eq("t5_no_push",  64'(got_data.size()), 64'd0);
        check_eq("t5_busy",     64'(busy),            64'd0);

        // Flush coinciding with a completing beat: one full word only
        acc_len = 8'd2;
        send_beat(1); send_beat(2);
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_word("t6", 32'd3, 1'b0);
        idle(6);
        check_eq("t6_single", 64'(got_data.size()), 64'd0);

        // Flush coinciding with a non-completing aligned beat includes it; the later beat opens a new group
        acc_len = 8'd8;
        send_beat(5); send_beat(6);
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_word("t6_va", 32'd5, 1'b1);
        idle(2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_word("t6_vb", 32'd6, 1'b1);

        // Backpressure: FIFO fills to 4 with no loss, then drains in order
        acc_len = 8'd1;
        out_ready = 1'b0;
        acc_n = 0;
        drop = -1;
        for (int c = 0; c < 12; c++) begin
            in_valid = 1'b1;
            if (in_ready) begin
                feed_sum = 32'(100 + acc_n);
                acc_n++;
            end else if (drop < 0) begin
                drop = c;
            end
            tick();
        end
        in_valid = 1'b0;
        check_eq("t7_ready_drop", 64'(drop),         64'd4);
        check_eq("t7_accepted",   64'(acc_n),        64'd4);
        check_eq("t7_fifo_cnt",   64'(dut.fifo_cnt), 64'd4);
        check_eq("t7_in_ready",   64'(in_ready),     64'd0);
        check_eq("t7_hold_valid", 64'(out_valid),    64'd1);
        check_eq("t7_hold_data",  64'(out_data),     64'd100);
        out_ready = 1'b1;
        expect_word("t7a", 32'd100, 1'b0);
        expect_word("t7b", 32'd101, 1'b0);
        expect_word("t7c", 32'd102, 1'b0);
        expect_word("t7d", 32'd103, 1'b0);
        idle(3);
        check_eq("t7_ready_back", 64'(in_ready), 64'd1);

        // Reset mid-group discards in-flight beats
        acc_len = 8'd4;
        send_beat(1); send_beat(1);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t8_rst_valid", 64'(out_valid), 64'd0);
        check_eq("t8_rst_ready", 64'(in_ready),  64'd1);
        check_eq("t8_rst_busy",  64'(busy),      64'd0);
        idle(6);
        check_eq("t8_no_word",   64'(got_data.size()), 64'd0);
        send_beat(1); send_beat(1); send_beat(1); send_beat(1);
        in_valid = 1'b0;
        expect_word("t8_fresh", 32'd4, 1'b0);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
